camera_scroll: RTL and testbench

//  Horizontal camera controller downstream of World: consumes mario_x each frame tick and produces
//  the `view` word World and the renderer use (right edge of the visible window, world pixels).

---
 rtl/camera_scroll_pkg.sv | 19 +
 rtl/camera_scroll_step.sv | 61 ++++++
 rtl/camera_scroll.sv | 137 +++++++++++++
 tb/tb_camera_scroll.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/camera_scroll_pkg.sv
// Shared game constants (coordinate widths, screen/level geometry) and the camera state type.
// World and the renderer import the same package so all blocks agree on geometry.
package camera_scroll_pkg;

  localparam int X_W        = 11;
  localparam int VIEW_W     = 33;
  localparam int SCREEN_W   = 640;
  localparam int LEVEL_W    = 2040;
  localparam int DEADZONE_X = 320;
  localparam int MAX_STEP   = 8;
  localparam int STEP_W     = 4;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    END   = 2'd2
  } cam_state_t;

endpackage

// File: rtl/camera_scroll_step.sv
// scroll_step: combinational camera step = min(dead-zone excess, MAX_STEP, room to the level edge).
// Optional macro SCROLL_BACK_EN adds a left dead zone and a direction output (1 = left).
module scroll_step #(
  parameter int X_W        = camera_scroll_pkg::X_W,
  parameter int VIEW_W     = camera_scroll_pkg::VIEW_W,
  parameter int SCREEN_W   = camera_scroll_pkg::SCREEN_W,
  parameter int LEVEL_W    = camera_scroll_pkg::LEVEL_W,
  parameter int DEADZONE_X = camera_scroll_pkg::DEADZONE_X,
  parameter int MAX_STEP   = camera_scroll_pkg::MAX_STEP
) (
  input  logic [X_W-1:0]    mario_x,
  input  logic [VIEW_W-1:0] left_wall,
  input  logic [VIEW_W-1:0] view,
  output logic [VIEW_W-1:0] step
`ifdef SCROLL_BACK_EN
  ,
  output logic              dir
`endif
);

`ifdef SCROLL_BACK_EN
  localparam logic [VIEW_W-1:0] DZ_RIGHT = VIEW_W'(SCREEN_W - DEADZONE_X);
  localparam logic [VIEW_W-1:0] DZ_LEFT  = VIEW_W'(DEADZONE_X / 2);
`else
  localparam logic [VIEW_W-1:0] DZ_RIGHT = VIEW_W'(DEADZONE_X);
`endif
  localparam logic [VIEW_W-1:0] STEP_MAX = VIEW_W'(MAX_STEP);
  localparam logic [VIEW_W-1:0] LEVEL    = VIEW_W'(LEVEL_W);

  function automatic logic [VIEW_W-1:0] min3(input logic [VIEW_W-1:0] a,
                                             input logic [VIEW_W-1:0] b,
                                             input logic [VIEW_W-1:0] c);
    logic [VIEW_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  logic [VIEW_W-1:0] mx, rel, need_r, room_r, step_r;

  assign mx     = VIEW_W'(mario_x);
  // Mario left of the wall counts as sitting on it, never a negative offset.
  assign rel    = (mx > left_wall) ? mx - left_wall : '0;
  assign need_r = (rel > DZ_RIGHT) ? rel - DZ_RIGHT : '0;
  assign room_r = (view < LEVEL) ? LEVEL - view : '0;
  assign step_r = min3(need_r, STEP_MAX, room_r);

`ifdef SCROLL_BACK_EN
  localparam logic [VIEW_W-1:0] SCREEN = VIEW_W'(SCREEN_W);
  logic [VIEW_W-1:0] need_l, room_l, step_l;

  assign need_l = (rel < DZ_LEFT) ? DZ_LEFT - rel : '0;
  assign room_l = (view > SCREEN) ? view - SCREEN : '0;
  assign step_l = min3(need_l, STEP_MAX, room_l);
  // Left and right zones are disjoint, so at most one step is non-zero.
  assign dir    = (step_l != '0);
  assign step   = dir ? step_l : step_r;
`else
  assign step   = step_r;
`endif

endmodule

// File: rtl/camera_scroll.sv
// camera_scroll: dead-zone horizontal camera, stepped once per frame tick, clamped at level end.
// Optional macro SCROLL_BACK_EN enables leftward scrolling and the scroll_dir output.
//
// state | meaning
// TRACK | camera follows Mario on each frame tick
// HOLD  | camera frozen (freeze asserted), ticks ignored
// END   | view reached LEVEL_W; outputs frozen until reset
module camera_scroll #(
  parameter int X_W        = camera_scroll_pkg::X_W,
  parameter int VIEW_W     = camera_scroll_pkg::VIEW_W,
  parameter int SCREEN_W   = camera_scroll_pkg::SCREEN_W,
  parameter int LEVEL_W    = camera_scroll_pkg::LEVEL_W,
  parameter int DEADZONE_X = camera_scroll_pkg::DEADZONE_X,
  parameter int MAX_STEP   = camera_scroll_pkg::MAX_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              freeze,
  input  logic [X_W-1:0]    mario_x,
  output logic [VIEW_W-1:0] view,
  output logic [VIEW_W-1:0] left_wall,
  output logic [3:0]        scroll_dx,
  output logic              view_upd,
  output logic              at_end
`ifdef SCROLL_BACK_EN
  ,
  output logic              scroll_dir
`endif
);

  import camera_scroll_pkg::*;

  localparam logic [VIEW_W-1:0] SCREEN = VIEW_W'(SCREEN_W);
  localparam logic [VIEW_W-1:0] LEVEL  = VIEW_W'(LEVEL_W);

  cam_state_t        state, state_nxt;
  logic [VIEW_W-1:0] view_nxt, left_wall_nxt, step;
  logic [3:0]        scroll_dx_nxt;
  logic              view_upd_nxt, at_end_nxt, upd;
`ifdef SCROLL_BACK_EN
  logic              step_dir, scroll_dir_nxt;
`endif

  scroll_step #(
    .X_W        (X_W),
    .VIEW_W     (VIEW_W),
    .SCREEN_W   (SCREEN_W),
    .LEVEL_W    (LEVEL_W),
    .DEADZONE_X (DEADZONE_X),
    .MAX_STEP   (MAX_STEP)
  ) u_step (
    .mario_x   (mario_x),
    .left_wall (left_wall),
    .view      (view),
    .step      (step)
`ifdef SCROLL_BACK_EN
    ,
    .dir       (step_dir)
`endif
  );

  always_comb begin
    state_nxt     = state;
    view_nxt      = view;
    left_wall_nxt = left_wall;
    scroll_dx_nxt = scroll_dx;
    view_upd_nxt  = 1'b0;
    at_end_nxt    = at_end;
    upd           = 1'b0;
`ifdef SCROLL_BACK_EN
    scroll_dir_nxt = scroll_dir;
`endif

    case (state)
      TRACK: begin
        // freeze takes priority over a coincident tick
        if (freeze)          state_nxt = HOLD;
        else if (frame_tick) upd = 1'b1;
      end
      HOLD: begin
        if (!freeze) state_nxt = TRACK;
      end
      END: begin
`ifdef SCROLL_BACK_EN
        if (!freeze && frame_tick && step_dir) upd = 1'b1;
`endif
      end
      default: state_nxt = TRACK;
    endcase

    if (upd) begin
`ifdef SCROLL_BACK_EN
      if (step_dir) begin
        view_nxt      = view - step;
        left_wall_nxt = left_wall - step;
      end else begin
        view_nxt      = view + step;
        left_wall_nxt = left_wall + step;
      end
      scroll_dir_nxt = step_dir;
`else
      view_nxt      = view + step;
      left_wall_nxt = left_wall + step;
`endif
      scroll_dx_nxt = step[3:0];
      view_upd_nxt  = 1'b1;
      at_end_nxt    = (view_nxt == LEVEL);
      state_nxt     = at_end_nxt ? END : TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= TRACK;
      view      <= SCREEN;
      left_wall <= '0;
      scroll_dx <= '0;
      view_upd  <= 1'b0;
      at_end    <= 1'b0;
`ifdef SCROLL_BACK_EN
      scroll_dir <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      view      <= view_nxt;
      left_wall <= left_wall_nxt;
      scroll_dx <= scroll_dx_nxt;
      view_upd  <= view_upd_nxt;
      at_end    <= at_end_nxt;
`ifdef SCROLL_BACK_EN
      scroll_dir <= scroll_dir_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_camera_scroll.sv
// Directed self-checking bench for camera_scroll (default build, forward-only scrolling).
module tb_camera_scroll;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        freeze = 1'b0;
  logic [10:0] mario_x = '0;
  logic [32:0] view, left_wall;
  logic [3:0]  scroll_dx;
  logic        view_upd, at_end;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  camera_scroll dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .mario_x    (mario_x),
    .view       (view),
    .left_wall  (left_wall),
    .scroll_dx  (scroll_dx),
    .view_upd   (view_upd),
    .at_end     (at_end)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the falling edge just after the update edge.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  int n_ticks;

  initial begin
    do_reset();
    check("rst_view", view, 640);
    check("rst_left_wall", left_wall, 0);
    check("rst_scroll_dx", scroll_dx, 0);
    check("rst_view_upd", view_upd, 0);
    check("rst_at_end", at_end, 0);

    // Inside the dead zone: updates strobe but the camera stays put.
    mario_x = 11'd100;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("dz_view_upd", view_upd, 1);
      check("dz_view", view, 640);
      check("dz_scroll_dx", scroll_dx, 0);
      @(negedge clk);
      check("dz_upd_drop", view_upd, 0);
    end

    mario_x = 11'd400;
    tick();
    check("step8_view", view, 648);
    check("step8_left_wall", left_wall, 8);
    check("step8_scroll_dx", scroll_dx, 8);
    // mario_x moves without a tick: nothing changes
    mario_x = 11'd1500;
    repeat (3) @(negedge clk);
    check("no_tick_view", view, 648);
    check("no_tick_upd", view_upd, 0);

    do_reset();
    mario_x = 11'd323;
    tick();
    check("step3_view", view, 643);
    check("step3_left_wall", left_wall, 3);
    check("step3_scroll_dx", scroll_dx, 3);
    tick();
    check("edge_dz_view", view, 643);
    check("edge_dz_scroll_dx", scroll_dx, 0);
    check("edge_dz_view_upd", view_upd, 1);

    // Saturate at the level end: 1400 px at 8 px per tick.
    do_reset();
    mario_x = 11'd2047;
    n_ticks = 0;
    for (int i = 0; i < 200; i++) begin
      if (at_end) break;
      tick();
      n_ticks++;
    end
    check("end_reached", at_end, 1);
    check("end_tick_count", n_ticks, 175);
    check("end_view", view, 2040);
    check("end_left_wall", left_wall, 1400);
    check("end_scroll_dx", scroll_dx, 8);
    tick();
    check("end_no_upd", view_upd, 0);
    check("end_view_held", view, 2040);
    check("end_at_end_held", at_end, 1);

    // freeze beats a coincident tick; ticks in HOLD are ignored.
    do_reset();
    mario_x = 11'd600;
    @(negedge clk) begin freeze = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) frame_tick = 1'b0;
    check("frz_view", view, 640);
    check("frz_upd", view_upd, 0);
    tick();
    check("hold_tick_view", view, 640);
    check("hold_tick_upd", view_upd, 0);
    @(negedge clk) freeze = 1'b0;
    @(negedge clk);
    tick();
    check("release_view", view, 648);
    check("release_scroll_dx", scroll_dx, 8);
    check("release_upd", view_upd, 1);

    // Reset mid-run; a coincident tick is discarded.
    mario_x = 11'd2000;
    for (int i = 0; i < 32; i++) tick();
    check("mid_view", view, 904);
    @(negedge clk) begin rst = 1'b0; frame_tick = 1'b1; end
    @(negedge clk) begin rst = 1'b1; frame_tick = 1'b0; end
    check("midrst_view", view, 640);
    check("midrst_left_wall", left_wall, 0);
    check("midrst_scroll_dx", scroll_dx, 0);
    check("midrst_upd", view_upd, 0);
    check("midrst_at_end", at_end, 0);
    tick();
    check("post_rst_view", view, 648);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
